// File: rtl/bgr_seq.sv
// bgr_seq: start-up sequencer and supervisor for N_CH bandgap macros.
// Each channel kicks porst, waits a settle time, checks vbg_ok, retries and latches a sticky fault.
module bgr_seq #(
  parameter int N_CH          = 4,
  parameter int KICK_CYCLES   = 16,
  parameter int SETTLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 3
) (
  input  logic            clk,
  input  logic            resetb,
  input  logic [N_CH-1:0] en,
  input  logic [N_CH-1:0] vbg_ok,
  input  logic [N_CH-1:0] clr_fault,
  output logic [N_CH-1:0] porst,
  output logic [N_CH-1:0] ready,
  output logic [N_CH-1:0] fault,
  output logic            all_ready
);

  localparam int MAX_CNT = (KICK_CYCLES > SETTLE_CYCLES) ? KICK_CYCLES : SETTLE_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam int RW      = $clog2(MAX_RETRY + 1);

  localparam logic [CW-1:0] KICK_LAST   = CW'(KICK_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_OFF,
    ST_KICK,
    ST_SETTLE,
    ST_READY,
    ST_FAULT
  } ch_state_e;

  // Two-flop synchroniser for the asynchronous comparator outputs
  logic [N_CH-1:0] sync1_reg;
  logic [N_CH-1:0] sync2_reg;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= vbg_ok;
      sync2_reg <= sync1_reg;
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    ch_state_e     state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [RW-1:0] retry_reg, retry_next;
    logic [RW-1:0] retry_inc;
    logic          porst_reg, ready_reg, fault_reg;
    logic          ok_s;

    assign ok_s      = sync2_reg[gi];
    assign retry_inc = retry_reg + RW'(1);

    always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      retry_next = retry_reg;
      if (state_reg == ST_FAULT) begin
        // Only an explicit clear leaves FAULT; en low is deliberately ignored here
        if (clr_fault[gi]) begin
          state_next = ST_OFF;
          cnt_next   = '0;
          retry_next = '0;
        end
      end else if (!en[gi]) begin
        state_next = ST_OFF;
        cnt_next   = '0;
        retry_next = '0;
      end else begin
        case (state_reg)
          ST_OFF: begin
            state_next = ST_KICK;
            cnt_next   = '0;
            retry_next = '0;
          end
          ST_KICK: begin
            if (cnt_reg == KICK_LAST) begin
              state_next = ST_SETTLE;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg + CW'(1);
            end
          end
          ST_SETTLE: begin
            if (cnt_reg == SETTLE_LAST) begin
              cnt_next = '0;
              if (ok_s) begin
                state_next = ST_READY;
                retry_next = '0;
              end else begin
                retry_next = retry_inc;
                state_next = (retry_inc == RETRY_LIMIT) ? ST_FAULT : ST_KICK;
              end
            end else begin
              cnt_next = cnt_reg + CW'(1);
            end
          end
          ST_READY: begin
            if (!ok_s) begin
              cnt_next   = '0;
              retry_next = retry_inc;
              state_next = (retry_inc == RETRY_LIMIT) ? ST_FAULT : ST_KICK;
            end
          end
          default: begin
            state_next = ST_OFF;
            cnt_next   = '0;
            retry_next = '0;
          end
        endcase
      end
    end

    // Outputs are registered decodes of the state, one clock behind it
    always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
        state_reg <= ST_OFF;
        cnt_reg   <= '0;
        retry_reg <= '0;
        porst_reg <= 1'b0;
        ready_reg <= 1'b0;
        fault_reg <= 1'b0;
      end else begin
        state_reg <= state_next;
        cnt_reg   <= cnt_next;
        retry_reg <= retry_next;
        porst_reg <= (state_reg == ST_KICK);
        ready_reg <= (state_reg == ST_READY);
        fault_reg <= (state_reg == ST_FAULT);
      end
    end

    assign porst[gi] = porst_reg;
    assign ready[gi] = ready_reg;
    assign fault[gi] = fault_reg;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      all_ready <= 1'b0;
    end else begin
      all_ready <= &ready;
    end
  end

endmodule

// File: tb/tb_bgr_seq.sv
// Self-checking bench for bgr_seq: timeline-based reference model, directed scenarios, then random traffic.
module tb_bgr_seq;
  localparam int N  = 2;
  localparam int K  = 4;
  localparam int S  = 8;
  localparam int MR = 2;

  logic         clk = 1'b0;
  logic         resetb;
  logic [N-1:0] en;
  logic [N-1:0] vbg_ok;
  logic [N-1:0] clr_fault;
  logic [N-1:0] porst;
  logic [N-1:0] ready;
  logic [N-1:0] fault;
  logic         all_ready;

  bgr_seq #(
    .N_CH(N), .KICK_CYCLES(K), .SETTLE_CYCLES(S), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .resetb(resetb), .en(en), .vbg_ok(vbg_ok), .clr_fault(clr_fault),
    .porst(porst), .ready(ready), .fault(fault), .all_ready(all_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_on = 1'b0;

  // Reference model: a channel is off, running an attempt that began at edge t0,
  // ready, or faulted. Kick/settle phases follow from elapsed edges since t0.
  localparam int M_OFF = 0, M_RUN = 1, M_RDY = 2, M_FLT = 3;
  int   mode [N];
  int   t0   [N];
  int   fails[N];
  logic h1   [N];
  logic h2   [N];
  int   edge_n = 0;
  logic [N-1:0] e_porst, e_ready, e_fault;
  logic         e_all;

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      mode[c] = M_OFF; t0[c] = 0; fails[c] = 0; h1[c] = 1'b0; h2[c] = 1'b0;
    end
    e_porst = '0; e_ready = '0; e_fault = '0; e_all = 1'b0;
  endtask

  task automatic attempt_failed(input int c);
    fails[c]++;
    if (fails[c] == MR) mode[c] = M_FLT;
    else begin mode[c] = M_RUN; t0[c] = edge_n; end
  endtask

  task automatic model_step();
    logic ok;
    edge_n++;
    e_all = &e_ready;
    for (int c = 0; c < N; c++) begin
      e_porst[c] = (mode[c] == M_RUN) && (edge_n - t0[c] <= K);
      e_ready[c] = (mode[c] == M_RDY);
      e_fault[c] = (mode[c] == M_FLT);
      ok = h2[c]; h2[c] = h1[c]; h1[c] = vbg_ok[c];
      if (mode[c] == M_FLT) begin
        if (clr_fault[c]) begin mode[c] = M_OFF; fails[c] = 0; end
      end else if (!en[c]) begin
        mode[c] = M_OFF; fails[c] = 0;
      end else if (mode[c] == M_OFF) begin
        mode[c] = M_RUN; t0[c] = edge_n; fails[c] = 0;
      end else if (mode[c] == M_RUN) begin
        if (edge_n - t0[c] == K + S) begin
          if (ok) begin mode[c] = M_RDY; fails[c] = 0; end
          else attempt_failed(c);
        end
      end else if (mode[c] == M_RDY) begin
        if (!ok) attempt_failed(c);
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge resetb);
      if (!resetb) model_reset();
      else model_step();
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Hand-computed expectation applied to both the DUT and the model
  task automatic pin(input string name, input logic act, input logic mdl, input logic want);
    chk({name, "_dut"}, 32'(act), 32'(want));
    chk({name, "_model"}, 32'(mdl), 32'(want));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("porst", 32'(porst), 32'(e_porst));
        chk("ready", 32'(ready), 32'(e_ready));
        chk("fault", 32'(fault), 32'(e_fault));
        chk("all_ready", 32'(all_ready), 32'(e_all));
      end
    end
  end

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetb = 1'b0; en = '0; clr_fault = '0;
    step(3);
    resetb = 1'b1;
  endtask

  initial begin
    resetb = 1'b0; en = '0; vbg_ok = '0; clr_fault = '0;
    step(2);
    chk_on = 1'b1;
    chk("reset_outputs", 32'({porst, ready, fault, all_ready}), 32'd0);
    do_reset();

    // Nominal start-up; en sampled at edge t
    vbg_ok = 2'b11; en = 2'b01;
    step(2);  pin("nom_porst_t1", porst[0], e_porst[0], 1'b1);
    step(3);  pin("nom_porst_t4", porst[0], e_porst[0], 1'b1);
    step(1);  pin("nom_porst_t5", porst[0], e_porst[0], 1'b0);
    step(7);  pin("nom_ready_t12", ready[0], e_ready[0], 1'b0);
    step(1);  pin("nom_ready_t13", ready[0], e_ready[0], 1'b1);
    step(1);  pin("nom_all_ready", all_ready, e_all, 1'b0);

    // Dropout of 3 samples starting at edge d
    vbg_ok[0] = 1'b0;
    step(3);  pin("drop_ready_d2", ready[0], e_ready[0], 1'b1);
    vbg_ok[0] = 1'b1;
    step(1);  pin("drop_ready_d3", ready[0], e_ready[0], 1'b0);
              pin("drop_kick_d3", porst[0], e_porst[0], 1'b1);
    step(12); pin("drop_ready_d15", ready[0], e_ready[0], 1'b1);
              pin("drop_fault", fault[0], e_fault[0], 1'b0);

    // clr_fault while READY is ignored
    clr_fault = 2'b01;
    step(1);  clr_fault = '0;
    step(2);  pin("clr_in_ready", ready[0], e_ready[0], 1'b1);

    // Retry then fault; en sampled at edge t
    do_reset();
    vbg_ok = 2'b00; en = 2'b01;
    step(14); pin("flt_kick2_t13", porst[0], e_porst[0], 1'b1);
    step(11); pin("flt_fault_t24", fault[0], e_fault[0], 1'b0);
    step(1);  pin("flt_fault_t25", fault[0], e_fault[0], 1'b1);
    step(6);  pin("flt_porst_t31", porst[0], e_porst[0], 1'b0);

    // Fault clear with en held high; clr sampled at edge c
    clr_fault = 2'b01;
    step(1);  clr_fault = '0;
              pin("clr_fault_c", fault[0], e_fault[0], 1'b1);
    step(1);  pin("clr_fault_c1", fault[0], e_fault[0], 1'b0);
              pin("clr_porst_c1", porst[0], e_porst[0], 1'b0);
    step(1);  pin("clr_porst_c2", porst[0], e_porst[0], 1'b1);

    // Abort mid-kick
    en[0] = 1'b0;
    step(1);  pin("abort_porst_a", porst[0], e_porst[0], 1'b1);
    step(1);  pin("abort_porst_a1", porst[0], e_porst[0], 1'b0);

    // Asynchronous reset with ch0 settling and ch1 kicking
    do_reset();
    vbg_ok = 2'b11; en = 2'b01;
    step(4);  en = 2'b11;
    step(4);  pin("rst_pre_porst1", porst[1], e_porst[1], 1'b1);
    resetb = 1'b0;
    #1;
    chk("async_rst_porst", 32'(porst), 32'd0);
    chk("async_rst_ready", 32'(ready), 32'd0);
    chk("async_rst_fault", 32'(fault), 32'd0);
    step(2);  resetb = 1'b1;
    step(2);  chk("restart_porst", 32'(porst), 32'(2'b11));

    // Randomised traffic
    for (int i = 0; i < 4000; i++) begin
      resetb = ($urandom_range(0, 1499) != 0);
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 39) == 0) en[c] = ~en[c];
        if (vbg_ok[c]) vbg_ok[c] = ($urandom_range(0, 59) != 0);
        else           vbg_ok[c] = ($urandom_range(0, 4) == 0);
        clr_fault[c] = ($urandom_range(0, 29) == 0);
      end
      step(1);
    end
    resetb = 1'b1; clr_fault = '0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
